pam4_lane_scheduler: RTL and testbench

- Round-robin scheduler that shares one PAM-4 symbol channel (pam_4_encode input) among NUM_LANES RS codeword sources (row/column encoder lanes of the 2D RS path).
- Grants the channel for exactly one whole codeword, which is N*SYMBOL_WIDTH/2 PAM-4 symbols. It then inserts GAP_CYCLES idle cycles and re-arbitrates.
- Emits frame_start, frame_end and lane tags so the downstream pam4_to_binary_rs collector and the BER counters stay codeword-aligned.

---
 rtl/pam4_sched_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/pam4_lane_scheduler.sv | 139 +++++++++++++
 tb/tb_pam4_lane_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pam4_sched_pkg.sv
// Shared types and helpers for the PAM-4 lane scheduler.
// The Gray-map helper is only referenced when PAM4_GRAY_MAP_EN is defined.
package pam4_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StGap
  } sched_state_e;

  function automatic int unsigned calc_syms_per_frame(input int unsigned n,
                                                      input int unsigned sym_w);
    return (n * sym_w) / 2;
  endfunction

  // Gray code to PAM-4 level: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray_to_level(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority search starting one past the last grant.
module rr_arbiter #(
  parameter int unsigned NUM_LANES = 4,
  localparam int unsigned LANE_W = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req_i,
  input  logic [LANE_W-1:0]    last_grant_i,
  output logic [LANE_W-1:0]    grant_idx_o,
  output logic                 grant_hit_o
);

  int unsigned idx;

  always_comb begin
    grant_idx_o = '0;
    grant_hit_o = 1'b0;
    idx         = 0;
    for (int unsigned i = 1; i <= NUM_LANES; i++) begin
      idx = 32'(last_grant_i) + i;
      if (idx >= NUM_LANES) begin
        idx = idx - NUM_LANES;
      end
      if (!grant_hit_o && req_i[idx[LANE_W-1:0]]) begin
        grant_hit_o = 1'b1;
        grant_idx_o = idx[LANE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pam4_lane_scheduler.sv
// Round-robin PAM-4 channel scheduler granting one whole RS codeword per lane.
// Optional PAM4_GRAY_MAP_EN remaps Gray-coded lane symbols to levels before registering.
module pam4_lane_scheduler
  import pam4_sched_pkg::*;
#(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned N            = 68,
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned GAP_CYCLES   = 2,
  localparam int unsigned SYMS_PER_FRAME = calc_syms_per_frame(N, SYMBOL_WIDTH),
  localparam int unsigned CNT_W          = $clog2(SYMS_PER_FRAME),
  localparam int unsigned LANE_W         = $clog2(NUM_LANES)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_LANES-1:0]   lane_valid_i,
  input  logic [2*NUM_LANES-1:0] lane_sym_i,
  output logic [NUM_LANES-1:0]   lane_ready_o,
  input  logic                   sink_ready_i,
  output logic [1:0]             symbol_out_o,
  output logic                   symbol_out_valid_o,
  output logic                   frame_start_o,
  output logic                   frame_end_o,
  output logic [LANE_W-1:0]      frame_lane_o,
  output logic                   busy_o,
  output logic [15:0]            frame_count_o
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sched_state_e      state_q, state_d;
  logic [LANE_W-1:0] grant_q, last_grant_q;
  logic [CNT_W-1:0]  sym_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [1:0]        sym_q;
  logic              valid_q, start_q, end_q;
  logic [15:0]       frame_count_q;

  logic [LANE_W-1:0] arb_idx;
  logic              arb_hit;
  logic              xfer, frame_last, gap_last;
  logic [1:0]        sym_sel, sym_mapped;

  rr_arbiter #(
    .NUM_LANES(NUM_LANES)
  ) u_arb (
    .req_i       (lane_valid_i),
    .last_grant_i(last_grant_q),
    .grant_idx_o (arb_idx),
    .grant_hit_o (arb_hit)
  );

  assign xfer       = (state_q == StStream) && lane_valid_i[grant_q] && sink_ready_i;
  assign frame_last = (sym_cnt_q == CNT_W'(SYMS_PER_FRAME - 1));
  assign gap_last   = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));
  assign sym_sel    = lane_sym_i[{grant_q, 1'b0} +: 2];

`ifdef PAM4_GRAY_MAP_EN
  assign sym_mapped = gray_to_level(sym_sel);
`else
  assign sym_mapped = sym_sel;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (arb_hit) state_d = StStream;
      StStream: if (xfer && frame_last) state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
      StGap:    if (gap_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Only the granted lane may be popped; the grant holds until the frame completes.
  always_comb begin
    lane_ready_o = '0;
    if (state_q == StStream) begin
      lane_ready_o[grant_q] = sink_ready_i & lane_valid_i[grant_q];
    end
  end

  assign busy_o = (state_q == StStream) || (state_q == StGap);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_q      <= '0;
      last_grant_q <= LANE_W'(NUM_LANES - 1);
    end else if ((state_q == StIdle) && arb_hit) begin
      grant_q      <= arb_idx;
      last_grant_q <= arb_idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sym_q         <= '0;
      valid_q       <= 1'b0;
      start_q       <= 1'b0;
      end_q         <= 1'b0;
      sym_cnt_q     <= '0;
      frame_count_q <= '0;
    end else begin
      valid_q <= xfer;
      start_q <= xfer && (sym_cnt_q == '0);
      end_q   <= xfer && frame_last;
      if (xfer) begin
        sym_q     <= sym_mapped;
        sym_cnt_q <= frame_last ? '0 : sym_cnt_q + 1'b1;
      end
      if (xfer && frame_last) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap_cnt_q <= '0;
    end else if (state_q == StGap) begin
      gap_cnt_q <= gap_last ? '0 : gap_cnt_q + 1'b1;
    end
  end

  assign symbol_out_o       = sym_q;
  assign symbol_out_valid_o = valid_q;
  assign frame_start_o      = start_q;
  assign frame_end_o        = end_q;
  assign frame_lane_o       = grant_q;
  assign frame_count_o      = frame_count_q;

endmodule

// File: tb/tb_pam4_lane_scheduler.sv
// Scoreboard bench for pam4_lane_scheduler: lane sources emit a Gray pattern,
// expected frames are queued when stimulus is set up and popped as symbols appear.
module tb_pam4_lane_scheduler;

  localparam int NL  = 4;
  localparam int SPF = 272;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  lane_valid = '0;
  logic [7:0]  lane_sym;
  logic [3:0]  lane_ready;
  logic        sink_ready = 1'b0;
  logic [1:0]  symbol_out;
  logic        sov, fs, fe;
  logic [1:0]  frame_lane;
  logic        busy;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  pam4_lane_scheduler #(
    .NUM_LANES   (NL),
    .N           (68),
    .SYMBOL_WIDTH(8),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .lane_valid_i      (lane_valid),
    .lane_sym_i        (lane_sym),
    .lane_ready_o      (lane_ready),
    .sink_ready_i      (sink_ready),
    .symbol_out_o      (symbol_out),
    .symbol_out_valid_o(sov),
    .frame_start_o     (fs),
    .frame_end_o       (fe),
    .frame_lane_o      (frame_lane),
    .busy_o            (busy),
    .frame_count_o     (frame_count)
  );

  typedef struct {
    logic [1:0] sym;
    logic       st;
    logic       en;
    logic [1:0] lane;
    int         fc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int out_cnt = 0;
  int phase_id = 0;
  int end_cyc = -1;
  int end_phase = -1;
  int fc_model = 0;
  int lane_frames[NL];
  int src_idx[NL];
  logic prev_ready = 1'b0;

  logic [1:0] pat[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
`ifdef PAM4_GRAY_MAP_EN
  logic [1:0] exp_tab[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
`else
  logic [1:0] exp_tab[4] = '{2'd0, 2'd1, 2'd3, 2'd2};
`endif

  assign lane_sym = {pat[(src_idx[3] + 3) % 4], pat[(src_idx[2] + 2) % 4],
                     pat[(src_idx[1] + 1) % 4], pat[src_idx[0] % 4]};

  // Sources advance one symbol per pop strobe.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NL; i++) src_idx[i] <= 0;
    end else begin
      for (int i = 0; i < NL; i++) if (lane_ready[i]) src_idx[i] <= src_idx[i] + 1;
    end
  end

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    prev_ready <= sink_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int l);
    exp_t e;
    int base;
    base = lane_frames[l] * SPF;
    fc_model++;
    for (int k = 0; k < SPF; k++) begin
      e.sym  = exp_tab[(base + k + l) % 4];
      e.st   = (k == 0);
      e.en   = (k == SPF - 1);
      e.lane = 2'(l);
      e.fc   = fc_model;
      sb.push_back(e);
    end
    lane_frames[l]++;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  task automatic wait_outs(input string tag, input int count);
    int target, n;
    target = out_cnt + count;
    n = 0;
    while (out_cnt < target && n < 2000) begin
      step();
      n++;
    end
    chk({tag, "_progress"}, 32'(out_cnt >= target), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_symbol_out"}, symbol_out, 0);
    chk({tag, "_valid"}, sov, 0);
    chk({tag, "_frame_start"}, fs, 0);
    chk({tag, "_frame_end"}, fe, 0);
    chk({tag, "_frame_lane"}, frame_lane, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_lane_ready"}, lane_ready, 0);
  endtask

  task automatic model_reset();
    sb.delete();
    fc_model = 0;
    for (int i = 0; i < NL; i++) lane_frames[i] = 0;
    phase_id++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      chk("lane_ready_legal", lane_ready & ~(lane_valid & {4{sink_ready}}), 0);
      chk("lane_ready_onehot0", 32'($onehot0(lane_ready)), 1);
      if (sov) begin
        chk("valid_after_ready", prev_ready, 1);
        if (sb.size() == 0) begin
          chk("unexpected_symbol", sov, 0);
        end else begin
          e = sb.pop_front();
          chk("symbol", symbol_out, e.sym);
          chk("frame_start", fs, e.st);
          chk("frame_end", fe, e.en);
          chk("frame_lane", frame_lane, e.lane);
          if (e.st && end_cyc >= 0 && end_phase == phase_id) begin
            chk("frame_spacing", cyc - end_cyc, GAP + 2);
          end
          if (e.en) begin
            chk("frame_count", frame_count, e.fc);
            end_cyc   = cyc;
            end_phase = phase_id;
          end
          out_cnt++;
        end
      end else begin
        chk("start_without_valid", fs, 0);
        chk("end_without_valid", fe, 0);
      end
    end
  end

  initial begin
    // Reset state.
    #3;
    check_all_zero("reset");
    repeat (3) step();
    rstn = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Single lane 2, two back-to-back frames.
    model_reset();
    push_frame(2);
    push_frame(2);
    lane_valid = 4'b0100;
    sink_ready = 1'b1;
    repeat (20) step();
    chk("busy_stream", busy, 1);
    wait_drain("lane2", 1500);
    lane_valid = 4'b0000;
    chk("lane2_count", frame_count, 2);

    // All lanes requesting from reset: order 0,1,2,3,0.
    repeat (10) step();
    rstn = 1'b0;
    #1;
    check_all_zero("reset2");
    model_reset();
    step();
    rstn = 1'b1;
    for (int l = 0; l < 5; l++) push_frame(l % NL);
    lane_valid = 4'b1111;
    wait_drain("rr", 3000);
    lane_valid = 4'b0000;
    chk("rr_count", frame_count, 5);

    // Backpressure toggling mid-frame on lane 3.
    repeat (10) step();
    phase_id++;
    push_frame(3);
    lane_valid = 4'b1000;
    repeat (30) step();
    for (int i = 0; i < 40; i++) begin
      sink_ready = ~sink_ready;
      step();
    end
    sink_ready = 1'b1;
    wait_drain("bp", 1000);
    lane_valid = 4'b0000;

    // Lane 1 stalls mid-frame while lane 3 requests; lane 3 waits for the gap.
    repeat (10) step();
    phase_id++;
    push_frame(1);
    push_frame(3);
    lane_valid = 4'b0010;
    wait_outs("stall", 50);
    lane_valid = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_no_ready", lane_ready, 0);
      chk("stall_lane", frame_lane, 1);
      chk("stall_busy", busy, 1);
    end
    lane_valid = 4'b1010;
    wait_drain("stall", 1500);
    lane_valid = 4'b0000;
    chk("stall_count", frame_count, 8);

    // Reset at symbol 100; pointer must return so lane 0 beats lane 3.
    repeat (10) step();
    phase_id++;
    push_frame(2);
    lane_valid = 4'b0100;
    wait_outs("midrst", 100);
    rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    lane_valid = 4'b1001;
    push_frame(0);
    push_frame(3);
    step();
    rstn = 1'b1;
    step();
    chk("midrst_count", frame_count, 0);
    wait_drain("midrst", 1500);
    lane_valid = 4'b0000;
    chk("midrst_final_count", frame_count, 2);
    repeat (10) step();
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
